// File: rtl/debug_snapshot_tx_pkg.sv
// Shared definitions for the debug snapshot transmitter: FSM state encodings,
// default frame header and section sizes, plus a word-to-byte helper.
package debug_snapshot_tx_pkg;

    // state     | meaning
    // ST_IDLE   | no frame in progress, waiting for start
    // ST_HDR    | presenting the header byte
    // ST_PC     | presenting the two PC bytes
    // ST_REGS   | presenting register file bytes
    // ST_MEM    | presenting data memory bytes
    // ST_CSUM   | presenting the checksum byte (checksum builds only)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_PC   = 3'd2;
    localparam logic [2:0] ST_REGS = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4;
    localparam logic [2:0] ST_CSUM = 3'd5;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         PC_BYTES       = 2;
    localparam int         WORD_BYTES     = 4;

    // Byte sel of a 32-bit word, most significant byte first.
    function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_snapshot_tx_byte_sel.sv
// Combinational byte selector: picks the frame byte for a given section and
// index out of the latched snapshot, so the FSM itself carries no wide muxes.
module debug_snapshot_tx_byte_sel
    import debug_snapshot_tx_pkg::*;
#(
    parameter int         PC_W     = 10,
    parameter int         NUM_REGS = 32,
    parameter int         NUM_MEM  = 10,
    parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
    input  logic [2:0]            section,
    input  logic [7:0]            index,
    input  logic [PC_W-1:0]       pcSnap,
    input  logic [32*NUM_REGS-1:0] regSnap,
    input  logic [32*NUM_MEM-1:0]  memSnap,
    input  logic [7:0]            csumByte,
    output logic [7:0]            byteOut
);

    logic [31:0] regWord;
    logic [31:0] memWord;
    logic [15:0] pcWide;

    // Word lookup by index[7:2], then byte pick by section and index[1:0].
    always_comb begin
        regWord = '0;
        memWord = '0;
        pcWide  = 16'(pcSnap);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (index[7:2] == 6'(i)) regWord = regSnap[32*i +: 32];
        end
        for (int j = 0; j < NUM_MEM; j++) begin
            if (index[7:2] == 6'(j)) memWord = memSnap[32*j +: 32];
        end
        case (section)
            ST_HDR:  byteOut = HEADER;
            ST_PC:   byteOut = index[0] ? pcWide[7:0] : pcWide[15:8];
            ST_REGS: byteOut = wordByte(regWord, index[1:0]);
            ST_MEM:  byteOut = wordByte(memWord, index[1:0]);
            ST_CSUM: byteOut = csumByte;
            default: byteOut = 8'h00;
        endcase
    end

endmodule

// File: rtl/debug_snapshot_tx.sv
// Debug snapshot transmitter: latches PC, register file and data memory on a
// start pulse and streams them as one byte frame over a valid/ready link.
// Optional macro DBG_CHECKSUM_EN appends a two's-complement checksum byte.
module debug_snapshot_tx
    import debug_snapshot_tx_pkg::*;
#(
    parameter int         PC_W     = 10,
    parameter int         NUM_REGS = 32,
    parameter int         NUM_MEM  = 10,
    parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [32*NUM_REGS-1:0] registers_in,
    input  logic [32*NUM_MEM-1:0]  memorias_in,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [7:0] PC_LAST  = 8'(PC_BYTES - 1);
    localparam logic [7:0] REG_LAST = 8'(WORD_BYTES * NUM_REGS - 1);
    localparam logic [7:0] MEM_LAST = 8'(WORD_BYTES * NUM_MEM - 1);

    logic [2:0]             state;
    logic [7:0]             byteCnt;
    logic [PC_W-1:0]        pcSnap;
    logic [32*NUM_REGS-1:0] regSnap;
    logic [32*NUM_MEM-1:0]  memSnap;
    logic [7:0]             curByte;
    logic [7:0]             csumByte;
    logic                   xfer;
    logic                   accept;

    // Outputs derive straight from state so an async reset drops them at once.
    assign busy     = (state != ST_IDLE);
    assign tx_valid = busy;
    assign tx_data  = busy ? curByte : 8'h00;
    assign xfer     = tx_valid && tx_ready;
    assign accept   = (state == ST_IDLE) && start;

    debug_snapshot_tx_byte_sel #(
        .PC_W     (PC_W),
        .NUM_REGS (NUM_REGS),
        .NUM_MEM  (NUM_MEM),
        .HEADER   (HEADER)
    ) uByteSel (
        .section  (state),
        .index    (byteCnt),
        .pcSnap   (pcSnap),
        .regSnap  (regSnap),
        .memSnap  (memSnap),
        .csumByte (csumByte),
        .byteOut  (curByte)
    );

    // Snapshot capture on an accepted start; the pipeline may run on afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcSnap  <= '0;
            regSnap <= '0;
            memSnap <= '0;
        end else if (accept) begin
            pcSnap  <= pc_in;
            regSnap <= registers_in;
            memSnap <= memorias_in;
        end
    end

`ifdef DBG_CHECKSUM_EN
    logic [7:0] csumAcc;

    // Running sum of every payload byte after the header.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csumAcc <= 8'h00;
        end else if (accept) begin
            csumAcc <= 8'h00;
        end else if (xfer && (state == ST_PC || state == ST_REGS || state == ST_MEM)) begin
            csumAcc <= csumAcc + tx_data;
        end
    end

    assign csumByte = 8'(8'h00 - csumAcc);
`else
    assign csumByte = 8'h00;
`endif

    // Frame sequencer: one section at a time, advancing only on a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            byteCnt <= 8'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_HDR;
                        byteCnt <= 8'd0;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        state   <= ST_PC;
                        byteCnt <= 8'd0;
                    end
                end
                ST_PC: begin
                    if (xfer) begin
                        if (byteCnt == PC_LAST) begin
                            state   <= ST_REGS;
                            byteCnt <= 8'd0;
                        end else begin
                            byteCnt <= byteCnt + 8'd1;
                        end
                    end
                end
                ST_REGS: begin
                    if (xfer) begin
                        if (byteCnt == REG_LAST) begin
                            state   <= ST_MEM;
                            byteCnt <= 8'd0;
                        end else begin
                            byteCnt <= byteCnt + 8'd1;
                        end
                    end
                end
                ST_MEM: begin
                    if (xfer) begin
                        if (byteCnt == MEM_LAST) begin
                            byteCnt <= 8'd0;
`ifdef DBG_CHECKSUM_EN
                            state   <= ST_CSUM;
`else
                            state   <= ST_IDLE;
                            done    <= 1'b1;
`endif
                        end else begin
                            byteCnt <= byteCnt + 8'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        state   <= ST_IDLE;
                        byteCnt <= 8'd0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    byteCnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_snapshot_tx.sv
// Directed bench for debug_snapshot_tx: frame contents, handshake stalls,
// ignored restarts, mid-frame reset and the optional checksum byte.
module tb_debug_snapshot_tx;

`ifdef DBG_CHECKSUM_EN
    localparam int FRAME_LEN = 172;
`else
    localparam int FRAME_LEN = 171;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [9:0]   pc_in;
    logic [1023:0] registers_in;
    logic [319:0] memorias_in;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         done;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] expFrame [0:255];
    int         expLen;
    logic [7:0] got [0:255];
    int         gotN;
    int         validCyc;
    int         doneCnt;

    always #5 clk = ~clk;

    debug_snapshot_tx dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pc_in        (pc_in),
        .registers_in (registers_in),
        .memorias_in  (memorias_in),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference frame from the snapshot currently on the inputs.
    task automatic buildFrame();
        int         k;
        logic [7:0] sum;
        expFrame[0] = 8'hA5;
        expFrame[1] = {6'b0, pc_in[9:8]};
        expFrame[2] = pc_in[7:0];
        k = 3;
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--) begin
                expFrame[k] = registers_in[32*r + 8*b +: 8];
                k++;
            end
        for (int m = 0; m < 10; m++)
            for (int b = 3; b >= 0; b--) begin
                expFrame[k] = memorias_in[32*m + 8*b +: 8];
                k++;
            end
        sum = 8'h00;
        for (int i = 1; i < k; i++) sum = sum + expFrame[i];
`ifdef DBG_CHECKSUM_EN
        expFrame[k] = 8'(8'h00 - sum);
        k++;
`endif
        expLen = k;
    endtask

    task automatic idleCheck(input string tag);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_data"},  32'(tx_data),  32'd0);
    endtask

    task automatic startFrame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_hdr",   32'(tx_data),  32'hA5);
    endtask

    // Runs from the current falling edge until done, an abort point or a timeout.
    task automatic collect(input bit randReady, input int pokeAt, input int abortAt);
        bit         holdPending;
        logic [7:0] holdData;
        bit         finished;
        bit         poked;
        int         lastXfer;
        gotN = 0; validCyc = 0; doneCnt = 0;
        holdPending = 0; finished = 0; poked = 0; lastXfer = -10;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (randReady) tx_ready = ($urandom_range(0, 3) != 0);
            if (holdPending && tx_valid !== 1'b1) chk("hold_valid", 32'(tx_valid), 32'd1);
            if (holdPending && tx_valid === 1'b1) chk("hold_data", 32'(tx_data), 32'(holdData));
            holdPending = 0;
            if (done) begin
                doneCnt++;
                chk("done_timing",   32'(cyc),      32'(lastXfer + 1));
                chk("frame_len",     32'(gotN),     32'(expLen));
                chk("done_valid_lo", 32'(tx_valid), 32'd0);
                chk("done_busy_lo",  32'(busy),     32'd0);
                finished = 1;
                break;
            end
            if (abortAt >= 0 && gotN == abortAt) begin
                reset = 1'b0;
                #1;
                chk("abort_valid", 32'(tx_valid), 32'd0);
                chk("abort_busy",  32'(busy),     32'd0);
                chk("abort_done",  32'(done),     32'd0);
                finished = 1;
                break;
            end
            if (pokeAt >= 0 && gotN == pokeAt && !poked) begin
                chk("poke_busy", 32'(busy), 32'd1);
                start        = 1'b1;
                registers_in = '1;
                poked        = 1;
            end else begin
                start = 1'b0;
            end
            if (tx_valid) begin
                validCyc++;
                if (tx_ready) begin
                    if (gotN < expLen) begin
                        if (tx_data !== expFrame[gotN])
                            chk($sformatf("byte%0d", gotN), 32'(tx_data), 32'(expFrame[gotN]));
                    end else begin
                        chk("extra_byte", 32'(gotN), 32'(expLen - 1));
                    end
                    if (gotN < 256) got[gotN] = tx_data;
                    gotN++;
                    lastXfer = cyc;
                end else begin
                    holdPending = 1;
                    holdData    = tx_data;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) chk("collect_timeout", 32'd0, 32'd1);
    endtask

    task automatic setTest2Snapshot();
        pc_in        = 10'h2A5;
        registers_in = '0;
        registers_in[63:32] = 32'h12345678;
        memorias_in  = '0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; tx_ready = 1'b0;
        pc_in = '0; registers_in = '0; memorias_in = '0;

        // 1: reset and quiet idle
        repeat (3) @(negedge clk);
        idleCheck("in_reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        idleCheck("idle_no_start");

        // 2: full frame with the sink always ready
        setTest2Snapshot();
        buildFrame();
        tx_ready = 1'b1;
        startFrame();
        chk("t2_busy", 32'(busy), 32'd1);
        collect(0, -1, -1);
        chk("t2_len",   32'(gotN), FRAME_LEN);
        chk("t2_b0",    32'(got[0]), 32'hA5);
        chk("t2_b1",    32'(got[1]), 32'h02);
        chk("t2_b2",    32'(got[2]), 32'hA5);
        chk("t2_b3",    32'(got[3]), 32'h00);
        chk("t2_b6",    32'(got[6]), 32'h00);
        chk("t2_b7",    32'(got[7]), 32'h12);
        chk("t2_b8",    32'(got[8]), 32'h34);
        chk("t2_b9",    32'(got[9]), 32'h56);
        chk("t2_b10",   32'(got[10]), 32'h78);
        chk("t2_b11",   32'(got[11]), 32'h00);
`ifdef DBG_CHECKSUM_EN
        chk("t2_csum",  32'(got[171]), 32'h45);
`endif
        chk("t2_no_bubbles", 32'(validCyc), 32'(gotN));
        chk("t2_done_cnt",   32'(doneCnt), 32'd1);

        // 3: same snapshot, stalling sink
        startFrame();
        collect(1, -1, -1);
        chk("t3_len", 32'(gotN), FRAME_LEN);
        chk("t3_b7",  32'(got[7]), 32'h12);
        tx_ready = 1'b1;

        // 4: restart and input change mid-frame are ignored
        startFrame();
        collect(0, 20, -1);
        chk("t4_len",  32'(gotN), FRAME_LEN);
        chk("t4_b10",  32'(got[10]), 32'h78);
        chk("t4_b100", 32'(got[100]), 32'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || done !== 1'b0) begin
                chk("t4_no_second_valid", 32'(tx_valid), 32'd0);
                chk("t4_no_second_done",  32'(done),     32'd0);
            end
        end
        chk("t4_idle_valid", 32'(tx_valid), 32'd0);

        // 5: reset at byte 50, then a fresh complete frame
        setTest2Snapshot();
        for (int j = 0; j < 10; j++) memorias_in[32*j +: 32] = 32'hC0DE0000 + 32'(j);
        buildFrame();
        startFrame();
        collect(0, -1, 50);
        chk("t5_abort_count", 32'(gotN), 32'd50);
        repeat (2) @(negedge clk);
        idleCheck("t5_in_reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        idleCheck("t5_after_reset");
        startFrame();
        collect(0, -1, -1);
        chk("t5_len",    32'(gotN), FRAME_LEN);
        chk("t5_b0",     32'(got[0]), 32'hA5);
        chk("t5_mem0_0", 32'(got[131]), 32'hC0);
        chk("t5_mem9_3", 32'(got[170]), 32'h09);

        // 6: near-empty snapshot, checksum or plain tail
        pc_in = 10'h001; registers_in = '0; memorias_in = '0;
        buildFrame();
        startFrame();
        collect(0, -1, -1);
        chk("t6_len",  32'(gotN), FRAME_LEN);
        chk("t6_pc_lo", 32'(got[2]), 32'h01);
`ifdef DBG_CHECKSUM_EN
        chk("t6_last", 32'(got[171]), 32'hFF);
`else
        chk("t6_last", 32'(got[170]), 32'h00);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
